// File: rtl/hot_page_mig_issuer_if.sv
// Migration request channel between the hot-page issuer and the migration engine.
// Handshake: a request transfers on every rising clk edge where req_valid and
// req_ready are both high; once req_valid rises, req_addr/req_rank stay stable
// and req_valid stays high until that transfer happens.
interface hot_page_mig_issuer_if #(
  parameter int WORD_SIZE = 28
);
  logic                 req_valid;
  logic                 req_ready;
  logic [WORD_SIZE-1:0] req_addr;
  logic [2:0]           req_rank;

  modport master (output req_valid, output req_addr, output req_rank, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_rank, output req_ready);
endinterface

// File: rtl/hot_page_mig_issuer.sv
// Hot-page migration issuer: once per epoch, snapshot the tracker's top-K
// pages, issue one migration request per valid page, then strobe mig_en so
// the tracker shifts the consumed entries out.
// Optional build macro MIG_DEDUP_EN: remember the pages issued in the previous
// epoch and skip snapshot slots that repeat one of them.
module hot_page_mig_issuer #(
  parameter int WORD_SIZE   = 28,
  parameter int ENTRY_WIDTH = 6,
  parameter int TOP_K       = 5,
  parameter int EPOCH_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [EPOCH_W-1:0]     epoch_len,
  input  logic [ENTRY_WIDTH-1:0] minptr,
  input  logic                   tracker_busy,
  input  logic [WORD_SIZE-1:0]   top_1,
  input  logic [WORD_SIZE-1:0]   top_2,
  input  logic [WORD_SIZE-1:0]   top_3,
  input  logic [WORD_SIZE-1:0]   top_4,
  input  logic [WORD_SIZE-1:0]   top_5,
  output logic                   mig_en,
  output logic [2:0]             num_mig,
  output logic                   epoch_done,
  output logic [15:0]            issued_total,
  output logic [2:0]             fsm_state,
  hot_page_mig_issuer_if.master  req
);

  typedef enum logic [2:0] {
    S_COUNT  = 3'd0,
    S_SNAP   = 3'd1,
    S_ISSUE  = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [WORD_SIZE-1:0] EMPTY = '1;

  state_t               state;
  logic [EPOCH_W-1:0]   cnt;
  logic [EPOCH_W-1:0]   last_cnt;
  logic [WORD_SIZE-1:0] tops [5];
  logic [WORD_SIZE-1:0] snap [TOP_K];
  logic [WORD_SIZE-1:0] cand [TOP_K];
  logic [TOP_K-1:0]     dup;
  logic [2:0]           n_valid;
  logic [2:0]           n_snap;
  logic [2:0]           lim;
  logic                 run;
  logic [2:0]           idx;
  logic [2:0]           start;
  logic [2:0]           limit;
  logic                 found;
  logic [2:0]           pos;

`ifdef MIG_DEDUP_EN
  logic [WORD_SIZE-1:0] hist_addr [TOP_K];
  logic [WORD_SIZE-1:0] cur_addr  [TOP_K];
  logic [TOP_K-1:0]     hist_vld;
  logic [TOP_K-1:0]     cur_vld;
`endif

  // Epoch length 0 behaves like 1; compare with >= so a shrunk length ends the epoch promptly.
  assign last_cnt = (epoch_len == '0) ? '0 : epoch_len - 1'b1;

  // Tracker ranks as an array for indexed access.
  always_comb begin
    tops[0] = top_1;
    tops[1] = top_2;
    tops[2] = top_3;
    tops[3] = top_4;
    tops[4] = top_5;
  end

  // Count the leading run of usable slots: below min(minptr, TOP_K) and not empty.
  always_comb begin
    lim    = (minptr < ENTRY_WIDTH'(TOP_K)) ? minptr[2:0] : 3'(TOP_K);
    n_snap = '0;
    run    = 1'b1;
    for (int i = 0; i < TOP_K; i++) begin
      if (run && (3'(i) < lim) && (tops[i] != EMPTY)) n_snap = n_snap + 3'd1;
      else run = 1'b0;
    end
  end

  // Candidate slot values (live tracker in SNAP, latched copy afterwards) and their repeat flags.
  always_comb begin
    for (int i = 0; i < TOP_K; i++) begin
      cand[i] = (state == S_SNAP) ? tops[i] : snap[i];
      dup[i]  = 1'b0;
`ifdef MIG_DEDUP_EN
      for (int j = 0; j < TOP_K; j++) begin
        if (hist_vld[j] && (hist_addr[j] == cand[i])) dup[i] = 1'b1;
      end
`endif
    end
  end

  // Locate the next slot to issue: first non-repeated slot in [start, limit).
  always_comb begin
    start = (state == S_SNAP) ? 3'd0 : idx + 3'd1;
    limit = (state == S_SNAP) ? n_snap : n_valid;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < TOP_K; i++) begin
      if (!found && (3'(i) >= start) && (3'(i) < limit) && !dup[i]) begin
        found = 1'b1;
        pos   = 3'(i);
      end
    end
  end

  // mig_en follows tracker_busy in the same cycle so it can never overlap a busy cycle.
  assign mig_en     = (state == S_COMMIT) && !tracker_busy;
  assign num_mig    = mig_en ? n_valid : 3'd0;
  assign epoch_done = (state == S_DONE);
  assign fsm_state  = state;

  // Epoch sequencer: count, snapshot, issue, commit, done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_COUNT;
      cnt           <= '0;
      n_valid       <= '0;
      idx           <= '0;
      req.req_valid <= 1'b0;
      req.req_addr  <= '0;
      req.req_rank  <= '0;
      issued_total  <= '0;
      for (int i = 0; i < TOP_K; i++) snap[i] <= EMPTY;
`ifdef MIG_DEDUP_EN
      hist_vld <= '0;
      cur_vld  <= '0;
      for (int i = 0; i < TOP_K; i++) begin
        hist_addr[i] <= '0;
        cur_addr[i]  <= '0;
      end
`endif
    end else begin
      case (state)
        S_COUNT: begin
          if (enable) begin
            if (cnt >= last_cnt) begin
              cnt   <= '0;
              state <= S_SNAP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_SNAP: begin
          for (int i = 0; i < TOP_K; i++) snap[i] <= tops[i];
          n_valid <= n_snap;
`ifdef MIG_DEDUP_EN
          cur_vld <= '0;
`endif
          if (n_snap == 3'd0) begin
            state <= S_DONE;
          end else if (found) begin
            req.req_valid <= 1'b1;
            req.req_addr  <= cand[pos];
            req.req_rank  <= pos;
            idx           <= pos;
            state         <= S_ISSUE;
          end else begin
            state <= S_COMMIT;
          end
        end
        S_ISSUE: begin
          if (req.req_ready) begin
            if (issued_total != 16'hFFFF) issued_total <= issued_total + 16'd1;
`ifdef MIG_DEDUP_EN
            cur_addr[idx] <= req.req_addr;
            cur_vld[idx]  <= 1'b1;
`endif
            if (found) begin
              req.req_addr <= cand[pos];
              req.req_rank <= pos;
              idx          <= pos;
            end else begin
              req.req_valid <= 1'b0;
              state         <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          if (!tracker_busy) state <= S_DONE;
        end
        S_DONE: begin
`ifdef MIG_DEDUP_EN
          hist_vld <= cur_vld;
          for (int i = 0; i < TOP_K; i++) hist_addr[i] <= cur_addr[i];
`endif
          state <= S_COUNT;
        end
        default: state <= S_COUNT;
      endcase
    end
  end

endmodule

// File: doc/hot_page_mig_issuer.md
Name: hot_page_mig_issuer

Overview:
Consumer end of the hot-page tracker. Once per programmable epoch it snapshots the tracker's top-K hottest page addresses and drops empty slots (all-ones). It issues one migration request per valid page over a valid/ready interface. When all requests are accepted, it pulses mig_en with num_mig back to the tracker so the migrated entries shift out.

Parameters:
WORD_SIZE, 28, page address width; matches the tracker word.
ENTRY_WIDTH, 6, tracker rank/pointer width.
TOP_K, 5, number of top slots consumed; legal range 1..5.
EPOCH_W, 32, epoch counter width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  epoch counter runs while high
epoch_len  in  EPOCH_W  cycles per epoch; 0 treated as 1
minptr  in  ENTRY_WIDTH  number of occupied tracker entries
tracker_busy  in  1  tracker write/sort in progress this cycle
top_1..top_5  in  WORD_SIZE each  tracker ranks 0..4; all-ones = empty
mig_en  out  1  one-cycle shift-out strobe to tracker
num_mig  out  3  entries to shift out; valid only while mig_en is high
req_valid  out  1  migration request valid
req_ready  in  1  downstream accepts request
req_addr  out  WORD_SIZE  page address to migrate
req_rank  out  3  source rank (0..TOP_K-1) of req_addr
epoch_done  out  1  one-cycle pulse at end of each epoch's processing
issued_total  out  16  saturating count of accepted requests

Behaviour:
- Reset values: all outputs 0; FSM to COUNT; epoch counter 0; snapshot registers all-ones.
- States:
  - COUNT: the counter increments while enable is high and holds while enable is low. When counter == max(epoch_len,1)-1, clear the counter and go to SNAP.
  - SNAP, 1 cycle:
    - Latch top_1..top_TOP_K into snap[0..TOP_K-1].
    - n_valid = min(minptr, TOP_K). Slots with rank >= n_valid, or holding all-ones, are marked invalid.
    - Valid slots are a prefix. Scanning stops at the first invalid slot.
    - If n_valid == 0, go to DONE. Otherwise set idx=0 and go to ISSUE.
  - ISSUE: drive req_valid=1, req_addr=snap[idx], req_rank=idx.
    - req_addr and req_rank are stable while req_valid && !req_ready.
    - On a req_valid && req_ready cycle: idx++ and issued_total++ (saturates at 0xFFFF).
    - When idx reaches n_valid, deassert req_valid on the next cycle and go to COMMIT.
    - Back-to-back acceptance: one request per cycle.
  - COMMIT: wait while tracker_busy=1. On the first cycle with tracker_busy=0, assert mig_en=1 with num_mig=n_valid for exactly one cycle, then go to DONE.
  - DONE: pulse epoch_done for 1 cycle, return to COUNT.
- Invariants:
  - num_mig <= minptr (at snapshot time) and num_mig <= TOP_K.
  - mig_en is never asserted together with req_valid, and never in a cycle with tracker_busy=1.
- enable deasserted mid-epoch-processing (SNAP/ISSUE/COMMIT): processing completes; only COUNT is gated.
- epoch_len changed mid-count: the new value applies at the next compare. If the counter is already >= the new value - 1, the epoch ends on the next enabled cycle.
- Reset mid-ISSUE or mid-COMMIT: outputs go low immediately (async). No mig_en is issued for that epoch.
- Latency, epoch end to first req_valid: 2 cycles (SNAP, then ISSUE).

Optional Feature:
Macro MIG_DEDUP_EN.
- With the macro defined:
  - Keep the TOP_K addresses issued in the previous epoch plus their valid bits.
  - In ISSUE, a snapshot slot equal to any previously issued address is skipped: no request, 0 cycles spent.
  - Skipped slots still count toward num_mig, because they are consumed from the tracker.
  - The history is replaced by this epoch's issued set in DONE and cleared by reset.
- Without the macro: no history registers; every valid slot is issued.

Test Plan:
1. epoch_len=10, enable=1, minptr=7, top_1..5=0x100..0x104, req_ready=1 -> SNAP at cycle 10; req_addr 0x100..0x104 on 5 consecutive cycles with req_rank 0..4; then mig_en=1 with num_mig=5 for 1 cycle; epoch_done pulses; issued_total=5.
2. minptr=2, top_3..5=all-ones -> exactly 2 requests (0x100, 0x101); num_mig=2.
3. minptr=0 -> no req_valid, no mig_en; epoch_done still pulses.
4. req_ready low for 3 cycles on the second request -> req_addr=0x101 and req_rank=1 held stable; total ISSUE length 5+3 cycles.
5. tracker_busy high for 4 cycles when COMMIT is entered -> mig_en asserts on the 5th cycle, and for 1 cycle only.
6. Reset asserted during ISSUE after 2 acceptances -> all outputs 0 asynchronously, FSM in COUNT, issued_total=0. With MIG_DEDUP_EN: repeat scenario 1 twice with identical top addresses -> second epoch issues 0 requests but mig_en carries num_mig=5.
